lynx_clk_reset_gen: RTL and testbench



---
 rtl/lynx_clk_reset_gen.sv | 128 ++++++++++++
 tb/tb_lynx_clk_reset_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lynx_clk_reset_gen.sv
// Lock-qualified system reset and 16/4 MHz clock-enable generator for the Lynx core (64 MHz clk).
// Optional lock-loss event counter enabled by defining RSTGEN_LOCK_LOSS_CNT_EN.
module lynx_clk_reset_gen #(
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 64,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       sys_reset,
  output logic       ready,
  output logic       ce_16m,
  output logic       ce_4m
`ifdef RSTGEN_LOCK_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_sync1;
  logic             r_sync2;
  logic             w_lock_s;
  logic [3:0]       r_pre;
  logic [3:0]       w_pre_nxt;
  logic             r_sys_reset;

  assign w_lock_s = r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = STABLE;
        end
      end
      STABLE: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nxt = HOLD;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
        end else if (r_cnt == HOLD_LAST) begin
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
        end
      end
      default: begin
        w_state_nxt = WAIT_LOCK;
      end
    endcase
  end

  // Prescaler restarts from zero on every entry into RUN so strobe phase is fixed to release.
  assign w_pre_nxt = ((r_state == RUN) && (w_state_nxt == RUN)) ? (r_pre + 4'd1) : 4'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= WAIT_LOCK;
      r_cnt       <= '0;
      r_pre       <= 4'd0;
      r_sys_reset <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pre       <= w_pre_nxt;
      r_sys_reset <= (w_state_nxt != RUN);
    end
  end

  assign sys_reset = r_sys_reset;
  assign ready     = ~r_sys_reset;
  assign ce_16m    = (r_state == RUN) && (r_pre[1:0] == 2'b11);
  assign ce_4m     = (r_state == RUN) && (r_pre == 4'hF);

`ifdef RSTGEN_LOCK_LOSS_CNT_EN
  logic [7:0] r_lock_loss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_loss_cnt <= 8'd0;
    end else if ((r_state == RUN) && (w_state_nxt == WAIT_LOCK) && (r_lock_loss_cnt != 8'hFF)) begin
      r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
    end
  end

  assign lock_loss_cnt = r_lock_loss_cnt;
`endif

endmodule

// File: tb/tb_lynx_clk_reset_gen.sv
// Bench for lynx_clk_reset_gen with STABLE_CYCLES=8, HOLD_CYCLES=4 (release 14 edges after lock).
// Vector table for power-up, lock-window model for glitch, lock-loss, saturation and rst pulse.
module tb_lynx_clk_reset_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       sys_reset;
  logic       ready;
  logic       ce_16m;
  logic       ce_4m;
  logic [7:0] act_llc;

  lynx_clk_reset_gen #(
    .STABLE_CYCLES(8),
    .HOLD_CYCLES  (4),
    .CNT_W        (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .sys_reset    (sys_reset),
    .ready        (ready),
    .ce_16m       (ce_16m),
    .ce_4m        (ce_4m)
`ifdef RSTGEN_LOCK_LOSS_CNT_EN
    ,
    .lock_loss_cnt(act_llc)
`endif
  );

`ifndef RSTGEN_LOCK_LOSS_CNT_EN
  assign act_llc = 8'd0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic lock;
    logic sr;
    logic c16;
    logic c4;
  } vec_t;

  typedef struct {
    int         phase;
    int         step;
    logic       sr;
    logic       c16;
    logic       c4;
    logic [7:0] llc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Release needs lock sampled high, rst low, on edges e-14..e-2 (sync delay plus 13 FSM edges).
  logic [14:0] m_vh  = '0;
  logic [1:0]  m_rs  = '0;
  logic        m_run = 1'b0;
  int          m_k   = 0;
  logic [7:0]  m_llc = 8'd0;

  task automatic drive(input int phase, input int step, input logic r, input logic l,
                       input logic use_tbl, input logic es, input logic e16, input logic e4);
    exp_t e;
    logic run;
    rst        = r;
    pll_locked = l;
    @(posedge clk);
    m_vh = {m_vh[13:0], (!r && l)};
    m_rs = {m_rs[0], r};
    run  = (&m_vh[14:2]) && (m_rs == 2'b00);
    if (r) m_llc = 8'd0;
    else if (m_run && !run && m_llc != 8'hFF) m_llc = m_llc + 8'd1;
    m_k   = run ? m_k + 1 : 0;
    m_run = run;
    e.phase = phase;
    e.step  = step;
    e.llc   = m_llc;
    if (use_tbl) begin
      e.sr  = es;
      e.c16 = e16;
      e.c4  = e4;
    end else begin
      e.sr  = !run;
      e.c16 = run && (m_k % 4 == 0);
      e.c4  = run && (m_k % 16 == 0);
    end
    sb.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic ok;
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      ok = (sys_reset === e.sr) && (ready === ~e.sr) && (ce_16m === e.c16) && (ce_4m === e.c4);
`ifdef RSTGEN_LOCK_LOSS_CNT_EN
      ok = ok && (act_llc === e.llc);
`endif
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL phase%0d step%0d: got sys_reset=%b ready=%b ce_16m=%b ce_4m=%b llc=%0d, required sys_reset=%b ready=%b ce_16m=%b ce_4m=%b llc=%0d",
                 e.phase, e.step, sys_reset, ready, ce_16m, ce_4m, act_llc,
                 e.sr, ~e.sr, e.c16, e.c4, e.llc);
      end
    end
  end

  initial begin
    vec_t tbl [73];
    int   k;
    int   waited;

    for (int i = 0; i < 3; i++) begin
      tbl[i].rst = 1'b1; tbl[i].lock = 1'b0;
      tbl[i].sr = 1'b1; tbl[i].c16 = 1'b0; tbl[i].c4 = 1'b0;
    end
    for (int i = 3; i < 23; i++) begin
      tbl[i].rst = 1'b0; tbl[i].lock = 1'b0;
      tbl[i].sr = 1'b1; tbl[i].c16 = 1'b0; tbl[i].c4 = 1'b0;
    end
    // Edge e counted from the first edge sampling lock high; RUN cycle k starts at 1 on edge 14.
    for (int e = 0; e < 50; e++) begin
      k = e - 13;
      tbl[23+e].rst  = 1'b0;
      tbl[23+e].lock = 1'b1;
      tbl[23+e].sr   = (e < 14);
      tbl[23+e].c16  = (k >= 1) && (k % 4 == 0);
      tbl[23+e].c4   = (k >= 1) && (k % 16 == 0);
    end

    for (int i = 0; i < 3; i++)
      drive(1, i, tbl[i].rst, tbl[i].lock, 1'b1, tbl[i].sr, tbl[i].c16, tbl[i].c4);

    checks++;
    if ((sys_reset !== 1'b1) || (ready !== 1'b0) || (ce_16m !== 1'b0) || (ce_4m !== 1'b0)
`ifdef RSTGEN_LOCK_LOSS_CNT_EN
        || (act_llc !== 8'd0)
`endif
       ) begin
      errors++;
      $display("FAIL reset state: got sys_reset=%b ready=%b ce_16m=%b ce_4m=%b llc=%0d, required 1 0 0 0 0",
               sys_reset, ready, ce_16m, ce_4m, act_llc);
    end

    for (int i = 3; i < 73; i++)
      drive(1, i, tbl[i].rst, tbl[i].lock, 1'b1, tbl[i].sr, tbl[i].c16, tbl[i].c4);

    // Lock drop during HOLD: no release at edge 14, release 14 edges after lock returns.
    drive(2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int e = 0; e < 43; e++)
      drive(2, e + 1, 1'b0, (e < 10 || e > 12), 1'b0, 1'b0, 1'b0, 1'b0);

    // Lock loss in RUN for two cycles, then recovery.
    for (int e = 0; e < 22; e++)
      drive(3, e, 1'b0, (e >= 2), 1'b0, 1'b0, 1'b0, 1'b0);

    // Repeated lock losses drive the event counter into saturation.
    for (int n = 0; n < 300; n++)
      for (int e = 0; e < 17; e++)
        drive(4, n * 17 + e, 1'b0, (e >= 2), 1'b0, 1'b0, 1'b0, 1'b0);

    // One-cycle rst pulse while running with steady lock.
    drive(5, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int e = 0; e < 24; e++)
      drive(5, e + 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Bounded wait for ready with steady lock.
    waited = 0;
    while ((ready !== 1'b1) && (waited < 20)) begin
      drive(6, waited, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      waited++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL phase6: ready not seen within %0d edges", waited);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
